// File: rtl/round_controller.sv
// Round-level game FSM: counts remaining round time from the seconds
// counter, handles start/pause/death and the post-round hold period.
//
// Ports:
//   clk25       25 MHz clock
//   reset_n     async active-low reset
//   seconds     seconds count from the timer stage (wraps 255->0)
//   start_btn   debounced level, rising edge starts/resumes
//   pause_btn   debounced level, rising edge pauses/resumes
//   player_dead level from game logic, honoured in PLAY only
//   timer_rst   registered 1-cycle clear to the seconds counter
//   state       0=IDLE 1=PLAY 2=PAUSE 3=OVER
//   time_left   remaining round seconds
//   round_end   1-cycle pulse on the first OVER cycle
//   end_reason  0=time expired, 1=player died
module round_controller #(
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned OVER_HOLD     = 3
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic [7:0] seconds,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       player_dead,
  output logic       timer_rst,
  output logic [1:0] state,
  output logic [7:0] time_left,
  output logic       round_end,
  output logic       end_reason
);

  localparam logic [7:0] LOAD      = 8'(ROUND_SECONDS);
  localparam logic [7:0] HOLD_LAST = 8'(OVER_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     cur;
  state_t     nxt;
  logic [7:0] seconds_q;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic [7:0] left_d;
  logic       start_q;
  logic       pause_q;
  logic       rst_d1;
  logic       rst_d;
  logic       end_d;
  logic       reason_d;
  logic       start_e;
  logic       pause_e;
  logic       tick;

  assign start_e = start_btn & ~start_q;
  assign pause_e = pause_btn & ~pause_q;

  // A change seen while the counter is being cleared (or on the cycle
  // after) is the clear itself, not a real second.
  assign tick = (seconds != seconds_q) & ~timer_rst & ~rst_d1;

  assign state = cur;

  always_comb begin
    nxt      = cur;
    left_d   = time_left;
    hold_d   = hold_q;
    rst_d    = 1'b0;
    end_d    = 1'b0;
    reason_d = end_reason;
    unique case (cur)
      IDLE: begin
        if (start_e) begin
          nxt      = PLAY;
          left_d   = LOAD;
          reason_d = 1'b0;
          rst_d    = 1'b1;
        end
      end
      PLAY: begin
        if (player_dead) begin
          nxt      = OVER;
          reason_d = 1'b1;
          rst_d    = 1'b1;
          end_d    = 1'b1;
          hold_d   = 8'd0;
        end else if (tick && time_left == 8'd1) begin
          nxt      = OVER;
          left_d   = 8'd0;
          reason_d = 1'b0;
          rst_d    = 1'b1;
          end_d    = 1'b1;
          hold_d   = 8'd0;
        end else begin
          // A pause edge does not swallow a coincident tick.
          if (tick && time_left != 8'd0) begin
            left_d = time_left - 8'd1;
          end
          if (pause_e) begin
            nxt = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (pause_e || start_e) begin
          nxt   = PLAY;
          rst_d = 1'b1;
        end
      end
      OVER: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            nxt    = IDLE;
            left_d = LOAD;
            hold_d = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= IDLE;
      time_left  <= LOAD;
      timer_rst  <= 1'b1;
      rst_d1     <= 1'b1;
      round_end  <= 1'b0;
      end_reason <= 1'b0;
      seconds_q  <= 8'd0;
      hold_q     <= 8'd0;
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
    end else begin
      cur        <= nxt;
      time_left  <= left_d;
      timer_rst  <= rst_d;
      rst_d1     <= timer_rst;
      round_end  <= end_d;
      end_reason <= reason_d;
      seconds_q  <= seconds;
      hold_q     <= hold_d;
      start_q    <= start_btn;
      pause_q    <= pause_btn;
    end
  end

endmodule
